// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time and
// buffers returned words, tagged with their fetch address, in a 2-entry FIFO
// that feeds decode. A flush empties the buffer and discards any in-flight
// read result.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no request outstanding; may issue if room in FIFO
// WAIT  | request outstanding; ack result is kept
// DROP  | request outstanding; ack result is discarded
module instr_fetch #(
  parameter int INSTR_W = 16
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic [7:0]         i_PC,
  input  logic               i_FLUSH,
  output logic [7:0]         o_MEM_ADDR,
  output logic               o_MEM_REQ,
  input  logic               i_MEM_ACK,
  input  logic [INSTR_W-1:0] i_MEM_DATA,
  output logic [INSTR_W-1:0] o_IR,
  output logic [7:0]         o_IR_PC,
  output logic               o_IR_VALID,
  input  logic               i_IR_READY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         fifo_pc    [0:1];
  logic [INSTR_W-1:0] fifo_instr [0:1];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  // Head of the FIFO is presented directly to decode.
  assign o_IR_VALID = (count != 2'd0);
  assign o_IR       = fifo_instr[rd_ptr];
  assign o_IR_PC    = fifo_pc[rd_ptr];

  // Flush wins over both push and pop; a returning word is only kept in WAIT.
  assign push = (state == WAIT) && i_MEM_ACK && !i_FLUSH;
  assign pop  = o_IR_VALID && i_IR_READY && !i_FLUSH;

  // Request FSM: issue when there is room, hold the request until acked.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state      <= IDLE;
      o_MEM_REQ  <= 1'b0;
      o_MEM_ADDR <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // Room is judged on the pre-edge count; a same-cycle pop does
          // not enable an issue until the following cycle.
          if (!i_FLUSH && (count < 2'd2)) begin
            o_MEM_ADDR <= i_PC;
            o_MEM_REQ  <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            state     <= IDLE;
          end else if (i_FLUSH) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          o_MEM_REQ <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Two-entry FIFO of {fetch address, instruction word}.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      fifo_pc[0]    <= 8'd0;
      fifo_pc[1]    <= 8'd0;
      fifo_instr[0] <= '0;
      fifo_instr[1] <= '0;
    end else if (i_FLUSH) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= o_MEM_ADDR;
        fifo_instr[wr_ptr] <= i_MEM_DATA;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-built corner-case
// sequences and random traffic checked against a queue-based reference.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic        flush;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        ack;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ready;

  int n_total = 0;
  int n_pass  = 0;

  instr_fetch #(.INSTR_W(16)) dut (
    .i_CLK      (clk),
    .i_RESET    (rst),
    .i_PC       (pc),
    .i_FLUSH    (flush),
    .o_MEM_ADDR (mem_addr),
    .o_MEM_REQ  (mem_req),
    .i_MEM_ACK  (ack),
    .i_MEM_DATA (mem_data),
    .o_IR       (ir),
    .o_IR_PC    (ir_pc),
    .o_IR_VALID (ir_valid),
    .i_IR_READY (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ins;
  } ent_t;

  ent_t       q[$];
  bit         m_busy;
  bit         m_drop;
  logic [7:0] m_addr;
  bit         m_req;

  task automatic model_step();
    bit pop_now, issue_now, deliver;
    if (rst) begin
      q.delete();
      m_busy = 0; m_drop = 0; m_addr = 8'h00; m_req = 0;
      return;
    end
    pop_now   = (q.size() > 0) && ready;
    issue_now = !m_busy && (q.size() < 2) && !flush;
    deliver   = 0;
    if (m_busy && ack) begin
      deliver = !m_drop && !flush;
      m_busy = 0; m_drop = 0; m_req = 0;
    end else if (m_busy && flush) begin
      m_drop = 1;
    end
    if (flush) begin
      q.delete();
    end else begin
      ent_t e;
      e.pc  = m_addr;
      e.ins = mem_data;
      if (pop_now) void'(q.pop_front());
      if (deliver) q.push_back(e);
    end
    if (issue_now) begin
      m_busy = 1; m_req = 1; m_addr = pc;
    end
  endtask

  // Advance one clock with the currently driven inputs and compare to model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("mem_req", {31'd0, mem_req}, {31'd0, m_req});
    check("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
    check("ir_valid", {31'd0, ir_valid}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      check("ir", {16'd0, ir}, {16'd0, q[0].ins});
      check("ir_pc", {24'd0, ir_pc}, {24'd0, q[0].pc});
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit a, input logic [15:0] d,
                       input logic [7:0] p, input bit rd);
    rst = r; flush = f; ack = a; mem_data = d; pc = p; ready = rd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        ack;
    logic [15:0] data;
    logic [7:0]  pc;
    logic        ready;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [7:0]  e_irpc;
  } vec_t;

  vec_t tbl [0:14];

  initial begin
    // basic fetch with one-cycle memory
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0, 16'h0000, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'hA1B2, 8'h05, 1'b1, 1'b0, 8'h05, 1'b1, 16'hA1B2, 8'h05};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0, 16'h0000, 8'h00};
    // fill the FIFO with decode stalled, then drain in order
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 16'h0000, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 8'h12, 1'b0, 1'b0, 8'h10, 1'b1, 16'h1111, 8'h10};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h12, 1'b0, 1'b1, 8'h12, 1'b1, 16'h1111, 8'h10};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h2222, 8'h14, 1'b0, 1'b0, 8'h12, 1'b1, 16'h1111, 8'h10};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h14, 1'b0, 1'b0, 8'h12, 1'b1, 16'h1111, 8'h10};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h14, 1'b0, 1'b0, 8'h12, 1'b1, 16'h1111, 8'h10};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h14, 1'b1, 1'b0, 8'h12, 1'b1, 16'h2222, 8'h12};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h14, 1'b0, 1'b1, 8'h14, 1'b1, 16'h2222, 8'h12};
    // push and pop on the same edge
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'h3333, 8'h20, 1'b1, 1'b0, 8'h14, 1'b1, 16'h3333, 8'h14};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h20, 1'b0, 1'b1, 8'h20, 1'b1, 16'h3333, 8'h14};
  end

  initial begin
    drive(1, 0, 0, 16'h0, 8'h0, 0);
    q.delete();
    m_busy = 0; m_drop = 0; m_addr = 8'h00; m_req = 0;
    #2;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].ack, tbl[i].data, tbl[i].pc, tbl[i].ready);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_req});
      check($sformatf("tbl%0d_addr", i), {24'd0, mem_addr}, {24'd0, tbl[i].e_addr});
      check($sformatf("tbl%0d_valid", i), {31'd0, ir_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid || tbl[i].rst) begin
        check($sformatf("tbl%0d_ir", i), {16'd0, ir}, {16'd0, tbl[i].e_ir});
        check($sformatf("tbl%0d_irpc", i), {24'd0, ir_pc}, {24'd0, tbl[i].e_irpc});
      end
    end

    // ---- slow memory: request held stable across a 4-cycle wait ----
    drive(1, 0, 0, 16'h0, 8'h30, 1); cycle();
    drive(0, 0, 0, 16'h0, 8'h30, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 16'h0, 8'h31, 0); cycle();
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", {24'd0, mem_addr}, 32'h30);
    end
    drive(0, 0, 1, 16'h3C3C, 8'h31, 0); cycle();
    check("slow_ir", {16'd0, ir}, 32'h3C3C);
    drive(0, 0, 0, 16'h0, 8'h31, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h31, 0); cycle();
    check("slow_one_push_irpc", {24'd0, ir_pc}, 32'h30);

    // ---- flush mid-wait with one buffered entry, then late ack dropped ----
    drive(1, 0, 0, 16'h0, 8'h40, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h40, 0); cycle();
    drive(0, 0, 1, 16'h4444, 8'h42, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h42, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h43, 0); cycle();
    drive(0, 1, 0, 16'h0, 8'h44, 0); cycle();
    check("flush_valid", {31'd0, ir_valid}, 32'd0);
    check("flush_req_held", {31'd0, mem_req}, 32'd1);
    drive(0, 1, 0, 16'h0, 8'h45, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h46, 0); cycle();
    drive(0, 0, 1, 16'hDEAD, 8'h47, 0); cycle();
    check("drop_valid", {31'd0, ir_valid}, 32'd0);
    check("drop_req", {31'd0, mem_req}, 32'd0);
    drive(0, 0, 0, 16'h0, 8'h50, 0); cycle();
    check("refetch_addr", {24'd0, mem_addr}, 32'h50);
    drive(0, 0, 1, 16'h5555, 8'h50, 0); cycle();
    check("refetch_ir", {16'd0, ir}, 32'h5555);

    // ---- flush coinciding with ack and pop ----
    drive(1, 0, 0, 16'h0, 8'h60, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h60, 0); cycle();
    drive(0, 0, 1, 16'h6666, 8'h62, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h62, 0); cycle();
    drive(0, 1, 1, 16'h6767, 8'h63, 1); cycle();
    check("fap_valid", {31'd0, ir_valid}, 32'd0);
    check("fap_req", {31'd0, mem_req}, 32'd0);
    drive(0, 0, 0, 16'h0, 8'h64, 1); cycle();
    check("fap_idle_issue", {24'd0, mem_addr}, 32'h64);

    // ---- reset mid-wait, late ack ignored ----
    drive(1, 0, 0, 16'h0, 8'h70, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h70, 0); cycle();
    drive(0, 0, 0, 16'h0, 8'h71, 0); cycle();
    drive(1, 0, 1, 16'h7070, 8'h71, 1); cycle();
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_irpc", {24'd0, ir_pc}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    drive(0, 0, 1, 16'h7171, 8'h72, 0); cycle();
    check("rst_restart_addr", {24'd0, mem_addr}, 32'h72);
    check("late_ack_ignored", {31'd0, ir_valid}, 32'd0);
    drive(0, 0, 0, 16'h0, 8'h73, 0); cycle();
    drive(0, 0, 1, 16'h7777, 8'h73, 0); cycle();
    check("rst_refetch_ir", {16'd0, ir}, 32'h7777);

    // ---- random traffic against the model ----
    drive(1, 0, 0, 16'h0, 8'h0, 0); cycle();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0), 16'($urandom), 8'($urandom),
            ($urandom_range(0, 1) == 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
